main_control_fsm: RTL and testbench

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

---
 rtl/mips_ctrl_pkg.sv | 30 +++
 rtl/main_control_fsm_if.sv | 33 +++
 rtl/main_control_fsm.sv | 136 +++++++++++++
 tb/tb_main_control_fsm.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control blocks: state codes, opcodes, ALU op codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_I_EXEC    = 4'd10,
    ST_I_WB      = 4'd11
  } ctrl_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/main_control_fsm_if.sv
// Control bundle between the main control FSM (master) and the multicycle datapath (slave).
interface main_control_fsm_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       ir_write;
  logic       alu_src_a;
  logic       reg_write;
  logic       reg_dst;
  logic [1:0] pc_source;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       illegal_op;

  modport master (
    input  op, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
           ir_write, alu_src_a, reg_write, reg_dst, pc_source, alu_src_b,
           alu_op, illegal_op
  );

  modport slave (
    output op, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
           ir_write, alu_src_a, reg_write, reg_dst, pc_source, alu_src_b,
           alu_op, illegal_op
  );
endinterface

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control FSM; addi support when MAIN_CONTROL_ADDI_EN is defined.
// Latency (mem_ready=1): lw 5, sw/R/addi 4, beq/j 3 cycles.
// Stalls in FETCH, MEM_READ and MEM_WRITE until mem_ready; write enables held low during rst.
module main_control_fsm
  import mips_ctrl_pkg::*;
(
  input logic                clk,
  input logic                rst,
  main_control_fsm_if.master bus
);

  ctrl_state_t state, state_nxt;
  logic        illegal_q;
  logic        dec_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (dec_illegal) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt         = state;
    dec_illegal       = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.ir_write      = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.pc_source     = 2'b00;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = ALU_ADD;

    case (state)
      ST_FETCH: begin
        // PC+4 and IR load happen only on the cycle memory delivers the word
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        bus.alu_src_b = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_nxt = ST_MEM_ADDR;
          OP_RTYPE:     state_nxt = ST_R_EXEC;
          OP_BEQ:       state_nxt = ST_BRANCH;
          OP_J:         state_nxt = ST_JUMP;
`ifdef MAIN_CONTROL_ADDI_EN
          OP_ADDI:      state_nxt = ST_I_EXEC;
`endif
          default: begin
            state_nxt   = ST_FETCH;
            dec_illegal = 1'b1;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_nxt     = (bus.op == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      end
      ST_MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        if (bus.mem_ready) state_nxt = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        state_nxt      = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        if (bus.mem_ready) state_nxt = ST_FETCH;
      end
      ST_R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_FUNCT;
        state_nxt     = ST_R_WB;
      end
      ST_R_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        state_nxt     = ST_FETCH;
      end
      ST_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = ALU_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        state_nxt         = ST_FETCH;
      end
      ST_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        state_nxt     = ST_FETCH;
      end
`ifdef MAIN_CONTROL_ADDI_EN
      ST_I_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_nxt     = ST_I_WB;
      end
      ST_I_WB: begin
        bus.reg_write = 1'b1;
        state_nxt     = ST_FETCH;
      end
`endif
      default: state_nxt = ST_FETCH;
    endcase

    // Reset is synchronous, so the old state is still visible this cycle; suppress its writes
    if (rst) begin
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.ir_write      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.reg_write     = 1'b0;
    end
  end

  assign bus.illegal_op = illegal_q & ~rst;

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: per-cycle control-word and illegal_op checks.
module tb_main_control_fsm;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  main_control_fsm_if bus();

  main_control_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write,
  //  alu_src_a, reg_write, reg_dst, pc_source[1:0], alu_src_b[1:0], alu_op[1:0]}
  localparam logic [15:0] C_FETCH1 = 16'h9204;
  localparam logic [15:0] C_FETCH0 = 16'h1004;
  localparam logic [15:0] C_DECODE = 16'h000C;
  localparam logic [15:0] C_MADDR  = 16'h0108;
  localparam logic [15:0] C_MREAD  = 16'h3000;
  localparam logic [15:0] C_MWB    = 16'h0480;
  localparam logic [15:0] C_MWRITE = 16'h2800;
  localparam logic [15:0] C_REXEC  = 16'h0102;
  localparam logic [15:0] C_RWB    = 16'h00C0;
  localparam logic [15:0] C_BRANCH = 16'h4111;
  localparam logic [15:0] C_JUMP   = 16'h8020;
`ifdef MAIN_CONTROL_ADDI_EN
  localparam logic [15:0] C_IEXEC  = 16'h0108;
  localparam logic [15:0] C_IWB    = 16'h0080;
`endif

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ctl();
    return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
            bus.mem_to_reg, bus.ir_write, bus.alu_src_a, bus.reg_write, bus.reg_dst,
            bus.pc_source, bus.alu_src_b, bus.alu_op};
  endfunction

  // One clock cycle: drive inputs just after the edge, check settled outputs, advance.
  task automatic cyc(input string tag, input logic [5:0] o, input logic mr, input logic r,
                     input logic [15:0] exp, input logic ill);
    bus.op        = o;
    bus.mem_ready = mr;
    rst           = r;
    #1;
    check({tag, ".ctl"}, ctl(), exp);
    check({tag, ".ill"}, {15'b0, bus.illegal_op}, {15'b0, ill});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.op        = OP_RTYPE;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;

    // reset cycle: FETCH, mem_ready high but writes suppressed
    cyc("rst", OP_RTYPE, 1'b1, 1'b1, C_FETCH0, 1'b0);

    // lw
    cyc("lw.f",  OP_LW, 1'b1, 1'b0, C_FETCH1, 1'b0);
    cyc("lw.d",  OP_LW, 1'b1, 1'b0, C_DECODE, 1'b0);
    cyc("lw.a",  OP_LW, 1'b1, 1'b0, C_MADDR,  1'b0);
    cyc("lw.r",  OP_LW, 1'b1, 1'b0, C_MREAD,  1'b0);
    cyc("lw.wb", OP_LW, 1'b1, 1'b0, C_MWB,    1'b0);

    // R-type
    cyc("r.f",  OP_RTYPE, 1'b1, 1'b0, C_FETCH1, 1'b0);
    cyc("r.d",  OP_RTYPE, 1'b1, 1'b0, C_DECODE, 1'b0);
    cyc("r.x",  OP_RTYPE, 1'b1, 1'b0, C_REXEC,  1'b0);
    cyc("r.wb", OP_RTYPE, 1'b1, 1'b0, C_RWB,    1'b0);

    // sw with three wait cycles
    cyc("sw.f",  OP_SW, 1'b1, 1'b0, C_FETCH1, 1'b0);
    cyc("sw.d",  OP_SW, 1'b1, 1'b0, C_DECODE, 1'b0);
    cyc("sw.a",  OP_SW, 1'b1, 1'b0, C_MADDR,  1'b0);
    cyc("sw.w0", OP_SW, 1'b0, 1'b0, C_MWRITE, 1'b0);
    cyc("sw.w1", OP_SW, 1'b0, 1'b0, C_MWRITE, 1'b0);
    cyc("sw.w2", OP_SW, 1'b0, 1'b0, C_MWRITE, 1'b0);
    cyc("sw.w3", OP_SW, 1'b1, 1'b0, C_MWRITE, 1'b0);

    // beq
    cyc("beq.f", OP_BEQ, 1'b1, 1'b0, C_FETCH1, 1'b0);
    cyc("beq.d", OP_BEQ, 1'b1, 1'b0, C_DECODE, 1'b0);
    cyc("beq.b", OP_BEQ, 1'b1, 1'b0, C_BRANCH, 1'b0);

    // fetch stall, then j
    cyc("j.s0", OP_J, 1'b0, 1'b0, C_FETCH0, 1'b0);
    cyc("j.s1", OP_J, 1'b0, 1'b0, C_FETCH0, 1'b0);
    cyc("j.f",  OP_J, 1'b1, 1'b0, C_FETCH1, 1'b0);
    cyc("j.d",  OP_J, 1'b1, 1'b0, C_DECODE, 1'b0);
    cyc("j.j",  OP_J, 1'b1, 1'b0, C_JUMP,   1'b0);

    // addi
    cyc("addi.f", OP_ADDI, 1'b1, 1'b0, C_FETCH1, 1'b0);
    cyc("addi.d", OP_ADDI, 1'b1, 1'b0, C_DECODE, 1'b0);
`ifdef MAIN_CONTROL_ADDI_EN
    cyc("addi.x",  OP_ADDI, 1'b1, 1'b0, C_IEXEC,  1'b0);
    cyc("addi.wb", OP_ADDI, 1'b1, 1'b0, C_IWB,    1'b0);
    cyc("addi.n",  OP_ADDI, 1'b0, 1'b0, C_FETCH0, 1'b0);
`else
    cyc("addi.il", OP_ADDI, 1'b0, 1'b0, C_FETCH0, 1'b1);
    cyc("addi.rs", OP_ADDI, 1'b0, 1'b1, C_FETCH0, 1'b0);
    cyc("addi.cl", OP_ADDI, 1'b0, 1'b0, C_FETCH0, 1'b0);
`endif

    // illegal opcode: sticky for the cycle after decode plus ten more, cleared by rst
    cyc("ill.f", 6'b111111, 1'b1, 1'b0, C_FETCH1, 1'b0);
    cyc("ill.d", 6'b111111, 1'b1, 1'b0, C_DECODE, 1'b0);
    for (int i = 0; i < 11; i++)
      cyc($sformatf("ill.h%0d", i), 6'b111111, 1'b0, 1'b0, C_FETCH0, 1'b1);
    cyc("ill.rs", 6'b111111, 1'b0, 1'b1, C_FETCH0, 1'b0);
    cyc("ill.cl", 6'b111111, 1'b0, 1'b0, C_FETCH0, 1'b0);

    // reset in the middle of a load
    cyc("mr.f",  OP_LW, 1'b1, 1'b0, C_FETCH1, 1'b0);
    cyc("mr.d",  OP_LW, 1'b1, 1'b0, C_DECODE, 1'b0);
    cyc("mr.a",  OP_LW, 1'b1, 1'b0, C_MADDR,  1'b0);
    cyc("mr.r",  OP_LW, 1'b0, 1'b0, C_MREAD,  1'b0);
    cyc("mr.rs", OP_LW, 1'b0, 1'b1, C_MREAD,  1'b0);
    cyc("mr.f2", OP_LW, 1'b1, 1'b0, C_FETCH1, 1'b0);
    cyc("mr.d2", OP_LW, 1'b1, 1'b0, C_DECODE, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
